// File: rtl/hazard3_instr_queue.sv
// Instruction queue between the fetch bus and the decoder: circular buffer with PC tracking and jump handling.
// Macro HAZARD3_IQ_COMPRESSED_EN selects halfword-granular storage; undefined gives word-granular storage.
module hazard3_instr_queue #(
  parameter int                 DEPTH_HW     = 8,
  parameter int                 W_ADDR       = 32,
  parameter logic [W_ADDR-1:0]  RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       fetch_data,
  input  logic              fetch_vld,
  input  logic              fetch_odd,
  output logic              fetch_rdy,
  output logic [31:0]       cir,
  output logic [1:0]        cir_vld,
  input  logic [1:0]        cir_use,
  input  logic              cir_lock,
  output logic [W_ADDR-1:0] cir_pc,
  input  logic              jump_now,
  input  logic [W_ADDR-1:0] jump_target
);

`ifdef HAZARD3_IQ_COMPRESSED_EN
  localparam int SLOTS  = DEPTH_HW;
  localparam int SLOT_W = 16;
`else
  localparam int SLOTS  = DEPTH_HW / 2;
  localparam int SLOT_W = 32;
`endif
  localparam int PW = $clog2(SLOTS);
  localparam int OW = $clog2(SLOTS + 1);

  logic [SLOT_W-1:0] r_mem [SLOTS];
  logic [PW-1:0]     r_rptr;
  logic [PW-1:0]     r_wptr;
  logic [OW-1:0]     r_occ;
  logic              r_pend;
  logic [W_ADDR-1:0] r_pend_pc;
  logic [W_ADDR-1:0] r_pc;

  logic              w_push;
  logic              w_pop;
  logic [OW-1:0]     w_push_n;
  logic [OW-1:0]     w_pop_n;
  logic [OW-1:0]     w_keep_n;
  logic [W_ADDR-1:0] w_pc_inc;
  logic [W_ADDR-1:0] w_target;
  logic              w_unused;

  // A jump cycle suppresses both sides of the queue regardless of cir_lock.
  assign w_push = fetch_vld && fetch_rdy && !jump_now;
  assign w_pop  = (cir_use != 2'd0) && !jump_now;
  assign cir_pc = r_pc;

`ifdef HAZARD3_IQ_COMPRESSED_EN
  assign fetch_rdy = (r_occ <= OW'(DEPTH_HW - 2));
  assign w_push_n  = !w_push ? '0 : (fetch_odd ? OW'(1) : OW'(2));
  assign w_pop_n   = w_pop ? OW'(cir_use) : '0;
  assign w_keep_n  = OW'(cir_vld);
  assign w_pc_inc  = W_ADDR'({cir_use, 1'b0});
  assign w_target  = {jump_target[W_ADDR-1:1], 1'b0};
  assign w_unused  = jump_target[0];

  always_comb begin
    cir     = '0;
    cir_vld = (r_occ >= OW'(2)) ? 2'd2 : r_occ[1:0];
    if (r_occ != '0)
      cir[15:0] = r_mem[r_rptr];
    if (r_occ >= OW'(2))
      cir[31:16] = r_mem[r_rptr + PW'(1)];
  end

  // An odd fetch carries only its upper halfword.
  always_ff @(posedge clk) begin
    if (w_push) begin
      if (fetch_odd) begin
        r_mem[r_wptr] <= fetch_data[31:16];
      end else begin
        r_mem[r_wptr]          <= fetch_data[15:0];
        r_mem[r_wptr + PW'(1)] <= fetch_data[31:16];
      end
    end
  end
`else
  assign fetch_rdy = (r_occ != OW'(SLOTS));
  assign w_push_n  = OW'(w_push);
  assign w_pop_n   = OW'(w_pop);
  assign w_keep_n  = OW'(r_occ != '0);
  assign w_pc_inc  = W_ADDR'(4);
  assign w_target  = {jump_target[W_ADDR-1:2], 2'b00};
  assign w_unused  = ^{fetch_odd, jump_target[1:0]};

  always_comb begin
    cir     = '0;
    cir_vld = 2'd0;
    if (r_occ != '0) begin
      cir     = r_mem[r_rptr];
      cir_vld = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= fetch_data;
  end
`endif

  // A locked jump keeps the instruction the decoder is holding and parks the target until it retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_occ  <= '0;
      r_pend <= 1'b0;
      r_pc   <= RESET_VECTOR;
    end else if (jump_now && !cir_lock) begin
      r_occ  <= '0;
      r_wptr <= r_rptr;
      r_pend <= 1'b0;
      r_pc   <= w_target;
    end else if (jump_now) begin
      r_occ  <= w_keep_n;
      r_wptr <= r_rptr + PW'(w_keep_n);
      r_pend <= 1'b1;
    end else begin
      r_occ  <= r_occ + w_push_n - w_pop_n;
      r_rptr <= r_rptr + PW'(w_pop_n);
      r_wptr <= r_wptr + PW'(w_push_n);
      if (w_pop) begin
        if (r_pend) begin
          r_pc   <= r_pend_pc;
          r_pend <= 1'b0;
        end else begin
          r_pc <= r_pc + w_pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (jump_now && cir_lock)
      r_pend_pc <= w_target;
  end

`ifdef FORMAL
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cir_use <= cir_vld);
`ifndef HAZARD3_IQ_COMPRESSED_EN
      assert (cir_use != 2'd1);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_hazard3_instr_queue.sv
// Directed bench for hazard3_instr_queue: fill/drain, wrap, jumps with and without lock, reset priority.
module tb_hazard3_instr_queue;
  localparam logic [31:0] RV = 32'h0000_1000;
`ifdef HAZARD3_IQ_COMPRESSED_EN
  localparam logic [31:0] JT = 32'h0000_0206;
`else
  localparam logic [31:0] JT = 32'h0000_0204;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_data;
  logic        fetch_vld;
  logic        fetch_odd;
  logic        fetch_rdy;
  logic [31:0] cir;
  logic [1:0]  cir_vld;
  logic [1:0]  cir_use;
  logic        cir_lock;
  logic [31:0] cir_pc;
  logic        jump_now;
  logic [31:0] jump_target;

  int total = 0;
  int bad   = 0;

  hazard3_instr_queue #(
    .DEPTH_HW    (8),
    .W_ADDR      (32),
    .RESET_VECTOR(RV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_data (fetch_data),
    .fetch_vld  (fetch_vld),
    .fetch_odd  (fetch_odd),
    .fetch_rdy  (fetch_rdy),
    .cir        (cir),
    .cir_vld    (cir_vld),
    .cir_use    (cir_use),
    .cir_lock   (cir_lock),
    .cir_pc     (cir_pc),
    .jump_now   (jump_now),
    .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fetch_vld = 1'b0; fetch_odd = 1'b0; cir_use = 2'd0;
    jump_now  = 1'b0; cir_lock  = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    idle();
    fetch_vld = 1'b1; fetch_data = d;
    tick();
    fetch_vld = 1'b0;
  endtask

  task automatic pop2();
    idle();
    cir_use = 2'd2;
    tick();
    cir_use = 2'd0;
  endtask

  task automatic jump(input logic lock, input logic [31:0] tgt);
    idle();
    jump_now = 1'b1; cir_lock = lock; jump_target = tgt;
    tick();
    jump_now = 1'b0; cir_lock = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] drain_exp [4];
    drain_exp[0] = 32'h7777_8888; drain_exp[1] = 32'h9999_AAAA;
    drain_exp[2] = 32'hBBBB_CCCC; drain_exp[3] = 32'h0000_0000;

    // Reset, with a push attempt that reset must override
    idle();
    fetch_data = 32'hFFFF_FFFF; jump_target = 32'h0;
    rst = 1'b1; fetch_vld = 1'b1;
    tick(); tick();
    rst = 1'b0; fetch_vld = 1'b0;
    chk("rst_cir", cir, 32'h0);
    chk("rst_vld", {30'd0, cir_vld}, 32'd0);
    chk("rst_rdy", {31'd0, fetch_rdy}, 32'd1);
    chk("rst_pc", cir_pc, RV);

    // Three words, no consumption
    push(32'h1111_2222);
    chk("fill1_cir", cir, 32'h1111_2222);
    push(32'h3333_4444);
    push(32'h5555_6666);
    chk("fill3_cir", cir, 32'h1111_2222);
    chk("fill3_vld", {30'd0, cir_vld}, 32'd2);
    chk("fill3_pc", cir_pc, RV);
    chk("fill3_rdy", {31'd0, fetch_rdy}, 32'd1);

    // Full: further fetches are refused
    push(32'h7777_8888);
    chk("full_rdy", {31'd0, fetch_rdy}, 32'd0);
    fetch_vld = 1'b1; fetch_data = 32'hDEAD_BEEF;
    tick(); tick();
    chk("full_hold_rdy", {31'd0, fetch_rdy}, 32'd0);
    chk("full_hold_cir", cir, 32'h1111_2222);

    // Pop while full: the same-cycle fetch is still refused
    cir_use = 2'd2;
    tick();
    chk("popfull_cir", cir, 32'h3333_4444);
    chk("popfull_pc", cir_pc, RV + 32'd4);
    chk("popfull_rdy", {31'd0, fetch_rdy}, 32'd1);

    // Simultaneous push and pop; write pointer wraps to slot 0
    fetch_data = 32'h9999_AAAA;
    tick();
    chk("pushpop_cir", cir, 32'h5555_6666);
    chk("pushpop_pc", cir_pc, RV + 32'd8);
    chk("pushpop_rdy", {31'd0, fetch_rdy}, 32'd1);
    cir_use = 2'd0; fetch_data = 32'hBBBB_CCCC;
    tick();
    fetch_vld = 1'b0;
    chk("refull_rdy", {31'd0, fetch_rdy}, 32'd0);

    // Drain across the wrap point
    cir_use = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) cir_use = 2'd0;
      chk($sformatf("drain%0d_cir", i), cir, drain_exp[i]);
      chk($sformatf("drain%0d_pc", i), cir_pc, RV + 32'd12 + 32'd4 * i);
    end
    chk("empty_vld", {30'd0, cir_vld}, 32'd0);

    // Unlocked jump discards queue contents and the same-cycle push/pop
    push(32'h1234_5678);
    idle();
    jump_now = 1'b1; jump_target = 32'h0000_0206;
    fetch_vld = 1'b1; fetch_data = 32'hAAAA_5555; cir_use = 2'd2;
    tick();
    idle();
    chk("jmp_vld", {30'd0, cir_vld}, 32'd0);
    chk("jmp_cir", cir, 32'h0);
    chk("jmp_pc", cir_pc, JT);
    push(32'hCAFE_F00D);
    chk("jmp_fill_cir", cir, 32'hCAFE_F00D);
    chk("jmp_fill_pc", cir_pc, JT);
    push(32'h0BAD_C0DE);
    pop2();
    chk("jmp_pop1_cir", cir, 32'h0BAD_C0DE);
    chk("jmp_pop1_pc", cir_pc, JT + 32'd4);
    pop2();
    chk("jmp_pop2_vld", {30'd0, cir_vld}, 32'd0);
    chk("jmp_pop2_pc", cir_pc, JT + 32'd8);

    // Locked jump keeps the current instruction and defers the target
    push(32'hA1A1_B1B1);
    push(32'hC1C1_D1D1);
    push(32'hE1E1_F1F1);
    idle();
    jump_now = 1'b1; cir_lock = 1'b1; jump_target = 32'h0000_0200;
    fetch_vld = 1'b1; fetch_data = 32'h1212_1212; cir_use = 2'd2;
    tick();
    idle();
    chk("lock_cir", cir, 32'hA1A1_B1B1);
    chk("lock_vld", {30'd0, cir_vld}, 32'd2);
    chk("lock_pc", cir_pc, JT + 32'd8);
    push(32'h3434_3434);
    chk("lock_app_cir", cir, 32'hA1A1_B1B1);
    chk("lock_app_pc", cir_pc, JT + 32'd8);
    pop2();
    chk("lock_pop_cir", cir, 32'h3434_3434);
    chk("lock_pop_pc", cir_pc, 32'h0000_0200);
    pop2();
    chk("lock_pop2_pc", cir_pc, 32'h0000_0204);
    chk("lock_pop2_vld", {30'd0, cir_vld}, 32'd0);

    // A second locked jump overwrites the pending target
    push(32'h7777_0000);
    jump(1'b1, 32'h0000_0300);
    jump(1'b1, 32'h0000_0400);
    chk("relock_pc_hold", cir_pc, 32'h0000_0204);
    pop2();
    chk("relock_pc", cir_pc, 32'h0000_0400);

    // An unlocked jump cancels a pending target
    push(32'h0101_0101);
    jump(1'b1, 32'h0000_0500);
    jump(1'b0, 32'h0000_0600);
    chk("cancel_pc", cir_pc, 32'h0000_0600);
    chk("cancel_vld", {30'd0, cir_vld}, 32'd0);
    push(32'h5A5A_5A5A);
    chk("cancel_cir", cir, 32'h5A5A_5A5A);
    pop2();
    chk("cancel_pop_pc", cir_pc, 32'h0000_0604);

    // Reset wins over jump, push and pop with the queue partly full
    push(32'h0F0F_0F0F);
    push(32'hF0F0_F0F0);
    rst = 1'b1; jump_now = 1'b1; jump_target = 32'h0000_0800;
    fetch_vld = 1'b1; fetch_data = 32'h6666_6666; cir_use = 2'd2;
    tick();
    rst = 1'b0; idle();
    chk("rst2_vld", {30'd0, cir_vld}, 32'd0);
    chk("rst2_cir", cir, 32'h0);
    chk("rst2_pc", cir_pc, RV);
    chk("rst2_rdy", {31'd0, fetch_rdy}, 32'd1);

`ifdef HAZARD3_IQ_COMPRESSED_EN
    // Halfword operation: odd fetch after a 2 mod 4 jump, then a 16-bit pop
    jump(1'b0, 32'h0000_0102);
    chk("c_jmp_pc", cir_pc, 32'h0000_0102);
    idle();
    fetch_vld = 1'b1; fetch_odd = 1'b1; fetch_data = 32'hBEEF_1234;
    tick();
    idle();
    chk("c_odd_vld", {30'd0, cir_vld}, 32'd1);
    chk("c_odd_cir", cir, 32'h0000_BEEF);
    push(32'h5678_1111);
    chk("c_mix_cir", cir, 32'h1111_BEEF);
    idle();
    cir_use = 2'd1;
    tick();
    idle();
    chk("c_pop1_pc", cir_pc, 32'h0000_0104);
    chk("c_pop1_cir", cir, 32'h5678_1111);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
